// File: rtl/lsram_pkg.sv
// Shared types, constants and configuration checks for the LSRAM-backed FIFO.
package lsram_pkg;

  localparam int unsigned LSRAM_BITS = 18432;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } out_state_t;

  // Level counters need one extra bit to represent a completely full FIFO.
  function automatic int unsigned fifo_lvl_w(input int unsigned aw);
    return aw + 1;
  endfunction

  // Legal aspect ratios of a single LSRAM block.
  function automatic bit cfg_ok(input int unsigned dw, input int unsigned aw);
    bit w_ok;
    w_ok = (dw == 1) || (dw == 2) || (dw == 4) || (dw == 8) || (dw == 9) ||
           (dw == 16) || (dw == 18) || (dw == 32) || (dw == 36);
    return w_ok && (aw >= 1) && (aw <= 14) && ((dw << aw) <= LSRAM_BITS);
  endfunction

endpackage

// File: rtl/lsram_tp_ram.sv
// Two-port RAM: one write port, one registered read port; storage has no reset.
module lsram_tp_ram #(
  parameter int unsigned DATA_WIDTH = 36,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  aclk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/lsram_fifo_fwft.sv
// First-word-fall-through FIFO on one LSRAM block, with a head register plus
// one prefetch register so reads can stream at one word per cycle.
module lsram_fifo_fwft
  import lsram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 36,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned AF_LEVEL   = (1 << ADDR_WIDTH) - 4,
  parameter int unsigned AE_LEVEL   = 4
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic                                flush,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [DATA_WIDTH-1:0]               s_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [DATA_WIDTH-1:0]               m_data,
  output logic [fifo_lvl_w(ADDR_WIDTH)-1:0]   level,
  output logic                                almost_full,
  output logic                                almost_empty
);

  localparam int unsigned LVL_W = fifo_lvl_w(ADDR_WIDTH);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  if (!cfg_ok(DATA_WIDTH, ADDR_WIDTH)) begin : g_cfg_err
    $error("lsram_fifo_fwft: illegal DATA_WIDTH/ADDR_WIDTH combination");
  end

  out_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] head_d;
  logic [DATA_WIDTH-1:0] pre_q, pre_d;
  logic                  pre_vld_q, pre_vld_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      ram_cnt_q, ram_cnt_d;
  logic [LVL_W-1:0]      level_d;
  logic                  m_valid_d, s_ready_d, af_d, ae_d;

  logic                  wr_hs, rd_hs, head_vld, head_vld_n, rd_issue, wr_en;
  logic [1:0]            buf_cnt;
  logic [DATA_WIDTH-1:0] ram_rdata;

  lsram_tp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .aclk    (aclk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (s_data),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rdata)
  );

  // Next-state: handshakes, RAM prefetch scheduling and output staging.
  always_comb begin
    wr_hs      = s_valid & s_ready;
    rd_hs      = m_valid & m_ready;
    head_vld   = (state_q == VALID);
    // Words held or owed to the output stage after this cycle's read; at most two fit.
    buf_cnt    = 2'(head_vld) + 2'(pre_vld_q) + 2'(inflight_q) - 2'(rd_hs);
    rd_issue   = (ram_cnt_q != '0) && (buf_cnt < 2'd2) && !flush;
    wr_en      = wr_hs & ~flush;

    head_d     = m_data;
    pre_d      = pre_q;
    pre_vld_d  = pre_vld_q;
    inflight_d = rd_issue;
    wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(wr_hs);
    rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(rd_issue);
    ram_cnt_d  = ram_cnt_q + LVL_W'(wr_hs) - LVL_W'(rd_issue);
    level_d    = level + LVL_W'(wr_hs) - LVL_W'(rd_hs);
    head_vld_n = head_vld & ~rd_hs;

    // Oldest data first: prefetch register, then the returning RAM word.
    if (!head_vld_n) begin
      if (pre_vld_q) begin
        head_d     = pre_q;
        head_vld_n = 1'b1;
        pre_vld_d  = inflight_q;
        if (inflight_q) pre_d = ram_rdata;
      end else if (inflight_q) begin
        head_d     = ram_rdata;
        head_vld_n = 1'b1;
      end
    end else if (inflight_q) begin
      pre_d     = ram_rdata;
      pre_vld_d = 1'b1;
    end

    state_d = head_vld_n ? VALID : (rd_issue ? FETCH : EMPTY);

    if (flush) begin
      state_d    = EMPTY;
      head_d     = '0;
      pre_d      = '0;
      pre_vld_d  = 1'b0;
      inflight_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      ram_cnt_d  = '0;
      level_d    = '0;
      head_vld_n = 1'b0;
    end

    m_valid_d = head_vld_n;
    s_ready_d = (level_d < LVL_W'(DEPTH));
    af_d      = (level_d >= LVL_W'(AF_LEVEL));
    ae_d      = (level_d <= LVL_W'(AE_LEVEL));
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= EMPTY;
      m_data       <= '0;
      m_valid      <= 1'b0;
      pre_q        <= '0;
      pre_vld_q    <= 1'b0;
      inflight_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_cnt_q    <= '0;
      level        <= '0;
      s_ready      <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      state_q      <= state_d;
      m_data       <= head_d;
      m_valid      <= m_valid_d;
      pre_q        <= pre_d;
      pre_vld_q    <= pre_vld_d;
      inflight_q   <= inflight_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_cnt_q    <= ram_cnt_d;
      level        <= level_d;
      s_ready      <= s_ready_d;
      almost_full  <= af_d;
      almost_empty <= ae_d;
    end
  end

endmodule

// File: tb/tb_lsram_fifo_fwft.sv
// Scoreboard bench for lsram_fifo_fwft at DEPTH=16, DATA_WIDTH=36.
module tb_lsram_fifo_fwft;

  logic        aclk = 1'b0;
  logic        aresetn, flush, s_valid, s_ready, m_valid, m_ready;
  logic        almost_full, almost_empty;
  logic [35:0] s_data, m_data;
  logic [4:0]  level;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [35:0] exp_q[$];

  lsram_fifo_fwft #(
    .DATA_WIDTH (36),
    .ADDR_WIDTH (4),
    .AF_LEVEL   (12),
    .AE_LEVEL   (4)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .flush        (flush),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    chk({tag, "_m_data"}, 64'(m_data), 64'd0);
    chk({tag, "_level"}, 64'(level), 64'd0);
    chk({tag, "_af"}, 64'(almost_full), 64'd0);
    chk({tag, "_ae"}, 64'(almost_empty), 64'd1);
  endtask

  // Monitor: inputs change just after posedge, so at negedge they show what the next edge accepts.
  logic        hold;
  logic [35:0] hold_data;
  always @(negedge aclk) begin
    if (!aresetn || flush) begin
      exp_q.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_data", 64'(m_data), 64'(hold_data));
      end
      chk("level_le_depth", 64'(level <= 5'd16), 64'd1);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL sb_underrun: got 0x%0h expected none", m_data);
        end else begin
          chk("sb_data", 64'(m_data), 64'(exp_q.pop_front()));
        end
      end
      if (s_valid && s_ready) exp_q.push_back(s_data);
      hold      = m_valid && !m_ready;
      hold_data = m_data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    aresetn = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    hold = 1'b0; hold_data = '0;
    cyc(); cyc();
    chk_reset_vals("rst");
    aresetn = 1'b1;
    cyc();
    chk("rst_rel_s_ready", 64'(s_ready), 64'd1);

    // Single word latency: written at edge t, visible after edge t+2.
    s_valid = 1'b1; s_data = 36'h1;
    cyc();
    s_valid = 1'b0;
    chk("lat_t_level", 64'(level), 64'd1);
    chk("lat_t_valid", 64'(m_valid), 64'd0);
    cyc();
    chk("lat_t1_valid", 64'(m_valid), 64'd0);
    cyc();
    chk("lat_t2_valid", 64'(m_valid), 64'd1);
    chk("lat_t2_data", 64'(m_data), 64'h1);
    chk("lat_t2_ae", 64'(almost_empty), 64'd1);
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    chk("lat_rd_level", 64'(level), 64'd0);
    chk("lat_rd_valid", 64'(m_valid), 64'd0);

    // Fill to 16 with no reads.
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 36'(i);
      cyc();
      chk("fill_level", 64'(level), 64'(i + 1));
      chk("fill_af", 64'(almost_full), 64'(i + 1 >= 12));
      chk("fill_s_ready", 64'(s_ready), 64'(i + 1 < 16));
    end
    s_data = 36'h99;
    cyc();
    chk("full_17th_level", 64'(level), 64'd16);
    chk("full_head", 64'(m_data), 64'd0);

    // Streaming at full: first cycle only reads, then read+write every cycle.
    m_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s_valid = 1'b1; s_data = 36'(100 + i);
      cyc();
      chk("stream_level", 64'(level), 64'd15);
      chk("stream_valid", 64'(m_valid), 64'd1);
    end
    s_valid = 1'b0; m_ready = 1'b0;

    // Random traffic until 2000 words are accepted.
    n = 0;
    for (int k = 0; k < 20000 && n < 2000; k++) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      s_data  = {4'($urandom), 32'($urandom)};
      if (s_valid && s_ready) n++;
      cyc();
    end
    chk("rand_words", 64'(n), 64'd2000);
    s_valid = 1'b0; m_ready = 1'b1;
    for (int k = 0; k < 200 && level != 0; k++) cyc();
    cyc();
    m_ready = 1'b0;
    chk("drain_level", 64'(level), 64'd0);
    chk("drain_valid", 64'(m_valid), 64'd0);
    chk("drain_sb_empty", 64'(exp_q.size()), 64'd0);

    // Flush at level 7 while a word is offered.
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1; s_data = 36'(8'h70 + i);
      cyc();
    end
    chk("pre_flush_level", 64'(level), 64'd7);
    flush = 1'b1; s_data = 36'hBAD;
    cyc();
    flush = 1'b0; s_valid = 1'b0;
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_valid", 64'(m_valid), 64'd0);
    chk("flush_s_ready", 64'(s_ready), 64'd1);
    chk("flush_ae", 64'(almost_empty), 64'd1);
    s_valid = 1'b1; s_data = 36'hA;
    cyc();
    s_valid = 1'b0;
    cyc(); cyc();
    chk("post_flush_valid", 64'(m_valid), 64'd1);
    chk("post_flush_data", 64'(m_data), 64'hA);
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    chk("post_flush_level", 64'(level), 64'd0);

    // Asynchronous reset mid-stream at level 9.
    for (int i = 0; i < 9; i++) begin
      s_valid = 1'b1; s_data = 36'(8'h90 + i);
      cyc();
    end
    s_valid = 1'b0;
    chk("pre_rst_level", 64'(level), 64'd9);
    aresetn = 1'b0;
    #1;
    chk_reset_vals("midrst");
    cyc();
    aresetn = 1'b1;
    cyc();
    chk("midrst_rel_s_ready", 64'(s_ready), 64'd1);
    s_valid = 1'b1; s_data = 36'h5;
    cyc();
    s_valid = 1'b0;
    cyc(); cyc();
    chk("midrst_valid", 64'(m_valid), 64'd1);
    chk("midrst_data", 64'(m_data), 64'h5);
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    cyc();
    chk("midrst_level", 64'(level), 64'd0);
    chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
